bcd_to_bin_serial: RTL and testbench

BCD_TO_BIN_SERIAL -- requirements
Module: bcd_to_bin_serial

---
 rtl/bcd_to_bin_serial.sv | 106 ++++++++++
 tb/tb_bcd_to_bin_serial.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_serial.sv
// Serial packed-BCD to binary converter: one digit per clock, MS digit first,
// using acc*10 = (acc<<3)+(acc<<1). Result and error flag are held until the next conversion.
//   state | meaning
//   IDLE  | waiting for start
//   CONV  | folding one digit per edge into the accumulator
//   DONE  | one-cycle result strobe; a new start is accepted here
module bcd_to_bin_serial #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] shreg_q, shreg_d;
  logic [BIN_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                errf_q, errf_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                err_q, err_d;

  logic [3:0]          digit;
  logic [BIN_W-1:0]    acc_next;
  logic                digit_bad;

  always_comb begin
    digit     = shreg_q[4*DIGITS-1 -: 4];
    digit_bad = (digit > 4'd9);
    // Invalid digits are folded in with their raw value; only the flag reports them.
    acc_next  = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    bin_d   = bin_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          shreg_d = bcd_in;
          acc_d   = '0;
          cnt_d   = '0;
          errf_d  = 1'b0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        acc_d   = acc_next;
        shreg_d = shreg_q << 4;
        cnt_d   = cnt_q + CNT_W'(1);
        errf_d  = errf_q | digit_bad;
        if (cnt_q == CNT_LAST) begin
          bin_d   = acc_next;
          err_d   = errf_q | digit_bad;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q == S_CONV);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Bench for bcd_to_bin_serial: per-cycle comparison against a timing/arithmetic model,
// directed literal cases, then randomized start/reset/bcd traffic.
module tb_bcd_to_bin_serial;
  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                busy, done, err;
  logic [BIN_W-1:0]    bin_out;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Result is the plain decimal value of the digits, wrapped to BIN_W bits.
  function automatic logic [BIN_W-1:0] ref_bin(input logic [4*DIGITS-1:0] v);
    longint s = 0;
    for (int i = DIGITS - 1; i >= 0; i--) s = s * 10 + longint'(v[4*i +: 4]);
    return BIN_W'(s);
  endfunction

  function automatic logic ref_err(input logic [4*DIGITS-1:0] v);
    logic e = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  // Model: a conversion occupies DIGITS cycles after the accepting edge, then one done cycle.
  int                  m_left  = 0;
  logic                m_done  = 1'b0;
  logic [BIN_W-1:0]    m_bin   = '0;
  logic                m_err   = 1'b0;
  logic [4*DIGITS-1:0] m_cap   = '0;
  logic                m_valid = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_left  = 0;
      m_bin   = '0;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_bin  = ref_bin(m_cap);
        m_err  = ref_err(m_cap);
      end
    end else if (start) begin
      m_cap  = bcd_in;
      m_left = DIGITS;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",    32'(busy),    32'(m_left > 0));
      chk("done",    32'(done),    32'(m_done));
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("err",     32'(err),     32'(m_err));
    end
  end

  // Pulse start with v and expect done after DIGITS+1 negedges with the literal result.
  task automatic run_conv(input logic [11:0] v, input int exp_bin, input logic exp_err);
    int k;
    int nbusy = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 12'($urandom);
      k = i;
      if (busy) nbusy++;
      if (done) break;
    end
    chk("latency",  32'(k),       32'(DIGITS + 1));
    chk("busy_len", 32'(nbusy),   32'(DIGITS));
    chk("lit_bin",  32'(bin_out), 32'(exp_bin));
    chk("lit_err",  32'(err),     32'(exp_err));
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int nd;
    int t1, t2;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_done", 32'(done),    32'd0);
    chk("rst_bin",  32'(bin_out), 32'd0);
    chk("rst_err",  32'(err),     32'd0);
    rst = 1'b0;

    run_conv(12'h123, 123, 1'b0);
    run_conv(12'h999, 999, 1'b0);
    run_conv(12'h000, 0,   1'b0);
    run_conv(12'h1A5, 205, 1'b1);
    run_conv(12'h042, 42,  1'b0);
    count_dones(2, nd);

    // start during CONV is ignored
    @(negedge clk); start = 1'b1; bcd_in = 12'h123;
    @(negedge clk); bcd_in = 12'h456;
    @(negedge clk); start = 1'b0;
    nd = 0; t1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin nd++; if (nd == 1) chk("ign_bin", 32'(bin_out), 32'd123); end
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_hold",  32'(bin_out), 32'd123);

    // reset on the second CONV edge aborts
    @(negedge clk); start = 1'b1; bcd_in = 12'h321;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(busy),    32'd0);
    chk("abort_bin",  32'(bin_out), 32'd0);
    chk("abort_err",  32'(err),     32'd0);
    count_dones(6, nd);
    chk("abort_ndone", 32'(nd), 32'd0);
    run_conv(12'h007, 7, 1'b0);

    // back-to-back via start held through DONE
    @(negedge clk); start = 1'b1; bcd_in = 12'h250;
    @(negedge clk); bcd_in = 12'h500;
    nd = 0; t1 = -1; t2 = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 4) start = 1'b0;
      if (done) begin
        nd++;
        if (nd == 1) begin t1 = i; chk("b2b_bin1", 32'(bin_out), 32'd250); end
        if (nd == 2) begin t2 = i; chk("b2b_bin2", 32'(bin_out), 32'd500); end
      end
    end
    chk("b2b_ndone", 32'(nd), 32'd2);
    chk("b2b_gap",   32'(t2 - t1), 32'(DIGITS + 1));

    // random traffic; the per-cycle compare checks everything
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      bcd_in = ($urandom_range(0, 3) == 0) ? 12'($urandom)
             : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rst    = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
